// File: rtl/dilate.sv
`default_nettype none
// ============================================================================
//  Module      : dilate
//  Description : Binary morphological dilation of a Width x Height bit-image
//                with a programmable 3x3 structuring mask. The whole frame is
//                computed in one combinational stage and registered together
//                with a valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dilate #(
    parameter int Width  = 8,
    parameter int Height = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [Width*Height-1:0]   imageIn,
    input  logic [8:0]                mask,
    output logic [Width*Height-1:0]   imageOut,
    output logic                      out_valid
);

    localparam int c_PIXELS = Width * Height;

    logic [c_PIXELS-1:0] w_dilated;
    logic [c_PIXELS-1:0] image_d;
    logic [c_PIXELS-1:0] image_q;
    logic                valid_d;
    logic                valid_q;

    // Row r sits at bits (Height-r)*Width-1 downward, column 0 is the row MSB.
    // Each output pixel ORs the nine mask-gated neighbours; neighbours that
    // fall outside the frame are tied to zero so nothing wraps across edges.
    for (genvar r = 0; r < Height; r++) begin : g_row
        for (genvar c = 0; c < Width; c++) begin : g_col
            logic [8:0] w_terms;
            for (genvar i = 0; i < 3; i++) begin : g_mi
                for (genvar j = 0; j < 3; j++) begin : g_mj
                    if ((r + i - 1 >= 0) && (r + i - 1 < Height) &&
                        (c + j - 1 >= 0) && (c + j - 1 < Width)) begin : g_in
                        assign w_terms[8-3*i-j] = mask[8-3*i-j] &
                            imageIn[(Height-(r+i-1))*Width-1-(c+j-1)];
                    end else begin : g_out
                        assign w_terms[8-3*i-j] = 1'b0;
                    end
                end
            end
            assign w_dilated[(Height-r)*Width-1-c] = |w_terms;
        end
    end

    // Load a new result on valid frames; otherwise hold the image and drop valid.
    always_comb begin
        image_d = image_q;
        valid_d = in_valid;
        if (in_valid) begin
            image_d = w_dilated;
        end
    end

    // Output registers, cleared asynchronously so an in-flight frame is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            image_q <= '0;
            valid_q <= 1'b0;
        end else begin
            image_q <= image_d;
            valid_q <= valid_d;
        end
    end

    assign imageOut  = image_q;
    assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dilate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dilate
//  Description : Directed self-checking bench for dilate (8x4 default build)
//                plus 1x1 and 5x3 builds compared against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dilate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] image_in = '0;
    logic [8:0]  mask = '0;
    logic [31:0] image_out;
    logic        out_valid;

    logic        s_valid = 1'b0;
    logic [8:0]  s_mask = '0;
    logic [0:0]  s1_img = '0;
    logic [0:0]  s1_out;
    logic        s1_ov;
    logic [14:0] s5_img = '0;
    logic [14:0] s5_out;
    logic        s5_ov;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    dilate #(.Width(8), .Height(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .imageIn(image_in),
        .mask(mask), .imageOut(image_out), .out_valid(out_valid)
    );

    dilate #(.Width(1), .Height(1)) u_dut11 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .imageIn(s1_img),
        .mask(s_mask), .imageOut(s1_out), .out_valid(s1_ov)
    );

    dilate #(.Width(5), .Height(3)) u_dut53 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .imageIn(s5_img),
        .mask(s_mask), .imageOut(s5_out), .out_valid(s5_ov)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference dilation for small frames packed into the low W*H bits.
    function automatic logic [31:0] model(input logic [31:0] img, input logic [8:0] m,
                                          input int w, input int h);
        logic [31:0] res;
        res = '0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        int rr;
                        int cc;
                        rr = r + i - 1;
                        cc = c + j - 1;
                        if (m[8-3*i-j] && rr >= 0 && rr < h && cc >= 0 && cc < w &&
                            img[(h-rr)*w-1-cc])
                            res[(h-r)*w-1-c] = 1'b1;
                    end
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        check("reset_img", image_out, 32'h0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;

        // Cross mask
        in_valid = 1'b1; image_in = 32'h0008_1000; mask = 9'b010_101_010;
        tick();
        check("cross_img", image_out, 32'h0814_2810);
        check("cross_valid", {31'd0, out_valid}, 32'd1);

        // Top-left neighbour only: image moves down-right
        mask = 9'b100_000_000;
        tick();
        check("tl_img", image_out, 32'h0000_0408);

        // Bottom-right neighbour only: image moves up-left
        mask = 9'b000_000_001;
        tick();
        check("br_img", image_out, 32'h1020_0000);

        // Corner clipping
        image_in = 32'h8000_0000; mask = 9'h1FF;
        tick();
        check("corner_tl", image_out, 32'hC0C0_0000);
        image_in = 32'h0000_0001;
        tick();
        check("corner_br", image_out, 32'h0000_0303);

        // Row-edge: right neighbour must not wrap to the previous row
        image_in = 32'h0081_0000; mask = 9'b000_001_000;
        tick();
        check("row_wrap", image_out, 32'h0002_0000);

        // Centre-only and zero mask
        image_in = 32'hA5C3_1E81; mask = 9'b000_010_000;
        tick();
        check("centre_only", image_out, 32'hA5C3_1E81);
        mask = 9'h000;
        tick();
        check("mask_zero", image_out, 32'h0);

        // Three back-to-back frames, then an idle cycle
        image_in = 32'h0008_1000; mask = 9'b010_101_010;
        tick();
        check("stream0", image_out, 32'h0814_2810);
        mask = 9'b100_000_000;
        tick();
        check("stream1", image_out, 32'h0000_0408);
        image_in = 32'hDEAD_BEEF; mask = 9'b000_010_000;
        tick();
        check("stream2", image_out, 32'hDEAD_BEEF);
        check("stream2_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0; image_in = 32'h0; mask = 9'h1FF;
        tick();
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_hold", image_out, 32'hDEAD_BEEF);

        // Asynchronous reset mid-cycle, frame in flight is discarded
        in_valid = 1'b1; image_in = 32'hFFFF_FFFF;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_img", image_out, 32'h0);
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("rst_hold_img", image_out, 32'h0);
        check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        check("post_rst_img", image_out, 32'h0);
        in_valid = 1'b1; image_in = 32'h8000_0000; mask = 9'h1FF;
        tick();
        check("post_rst_first", image_out, 32'hC0C0_0000);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;

        // Parameter sweep against the reference model
        s_valid = 1'b1;
        s1_img = 1'b1; s_mask = 9'h1EF;
        tick();
        check("w1_centre_off", {31'd0, s1_out}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            s_mask = 9'($urandom);
            s1_img = 1'($urandom);
            s5_img = 15'($urandom);
            tick();
            exp_v = model({31'd0, s1_img}, s_mask, 1, 1);
            check("w1h1_rand", {31'd0, s1_out}, exp_v);
            exp_v = model({17'd0, s5_img}, s_mask, 5, 3);
            check("w5h3_rand", {17'd0, s5_out}, exp_v);
            check("w5h3_valid", {31'd0, s5_ov}, 32'd1);
        end
        s_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dilate.md
# dilate

Binary morphological dilation of one Width×Height bit-image with a programmable 3×3 structuring mask. The block sits in the morphology datapath and feeds erode/open/close stages. It computes one full frame per clock from a single registered combinational stage. Output is registered with a valid flag.

## Interface
Parameters:
- Width, 8, image columns (≥1)
- Height, 4, image rows (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  imageIn/mask qualify this cycle
- imageIn  input  Width*Height  input frame
- mask  input  9  3×3 structuring element
- imageOut  output  Width*Height  dilated frame (registered)
- out_valid  output  1  imageOut holds a new result

## Operation
- Pixel packing: row r (0 = top) is imageIn[(Height-r)*Width-1 -: Width], so row 0 is the top bits. Within a row the MSB is column 0 (leftmost). imageOut uses the same packing.
- Mask packing: mask[8:6] is the top row, mask[5:3] the middle row and mask[2:0] the bottom row. Within each row the MSB is leftmost. Mask element (i,j), with i,j in 0..2, maps to offset (dr,dc) = (i-1, j-1).
- out(r,c) = OR over all mask elements with mask(i,j)=1 of in(r+dr, c+dc).
- Pixels outside the image read as 0. There is no wrap-around across row edges or frame edges.
- The centre bit mask[4] controls whether in(r,c) contributes to out(r,c). With mask[4]=0 an isolated pixel is not retained.
- mask=0 gives an all-zero output. mask=9'h1FF gives a full 8-neighbourhood dilation including the centre.
- The result is purely a function of the sampled imageIn and mask; there is no inter-frame state.

## Timing
- Latency is 1 cycle. At a rising clk edge with in_valid=1, imageOut is loaded with dilate(imageIn, mask) and out_valid is set to 1.
- At a rising clk edge with in_valid=0, out_valid goes to 0 and imageOut holds its previous value.
- Throughput is one frame per clock; back-to-back in_valid is allowed.
- Reset: when rst is asserted, imageOut=0 and out_valid=0 immediately, regardless of clk. A frame in flight is discarded. The first valid result after deassertion appears 1 cycle after the first sampled in_valid=1.
- imageIn and mask are sampled on the same edge. A mask change applies from the frame sampled on that edge.

## Test plan
- Reset: assert rst mid-frame → imageOut=0 and out_valid=0 immediately (asynchronously); both stay 0 until rst is released and an in_valid=1 frame is sampled.
- Cross mask, Width=8, Height=4: rows {00000000,00001000,00010000,00000000}, mask=9'b010_101_010 → one cycle later rows {00001000,00010100,00101000,00010000}, out_valid=1.
- Edge clipping: a single pixel at row 0/col 0 (imageIn bit 31), mask=9'h1FF → output bits 31,30,23,22 set; no other bits set, and nothing wraps to row 3 or column 7.
- Centre-only mask 9'b000_010_000 → imageOut equals imageIn. mask=0 → imageOut=0.
- Hold and stream: three consecutive in_valid=1 frames with different masks give three matching results on consecutive cycles. A following in_valid=0 cycle → out_valid=0 and imageOut is unchanged.
- Parameter sweep: Width=1/Height=1 and Width=5/Height=3 against a software model, with random images and masks.
